frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 16-bit words buffered (power of two, 2..16).
REQ-002 SHALL have port reclk  input  1  the single clock (rising edge), the same rising-edge pulse that clocks the memory unit.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset; 0 resets immediately, release is sampled on reclk.
REQ-004 SHALL have port sl  input  4  bit-position select currently driven to the memory unit by the counter.
REQ-005 SHALL have port din  input  16  parallel word output of the memory unit.
REQ-006 SHALL have port out_valid  output  1  head word available.
REQ-007 SHALL have port out_ready  input  1  consumer accepts head word.
REQ-008 SHALL have port out_data  output  16  head word; 16'h0000 when empty.
REQ-009 SHALL have port level  output  5  number of stored words, 0..DEPTH.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on sequence violation.
REQ-011 SHALL have port overflow  output  1  sticky flag, set when a complete frame is dropped because the buffer is full.
REQ-012 SHALL have port err_cnt  output  8  saturating count of sequence violations.

Function
REQ-013 SHALL sample sl each reclk and hold it as sl_prev for sequence checking.
REQ-014 SHALL implement tracker FSM states HUNT, COLLECT, ARMED.
REQ-015 HUNT: sl==0 -> COLLECT; any other value -> stay HUNT; no error is flagged in HUNT.
REQ-016 COLLECT: sl==sl_prev -> stay (hold); sl==sl_prev+1 -> stay, or ARMED if sl==15; any other value -> error.
REQ-017 ARMED: sl==15 -> stay (hold); sl==0 -> capture, then COLLECT; any other value -> error.
REQ-018 On error: frame_err=1 for that cycle, err_cnt increments (saturates at 255), next state COLLECT if sl==0, else HUNT; no capture.
REQ-019 Capture SHALL push din, as sampled on the capture edge (the word complete after the bit-15 write), into the FIFO.
REQ-020 Captured word SHALL appear on out_data with out_valid=1 one cycle after the capture edge, if the FIFO was empty.
REQ-021 Pop SHALL occur on an edge where out_valid && out_ready; head advances and level decrements that edge.
REQ-022 out_valid SHALL equal (level != 0); out_data SHALL be stable while out_valid && !out_ready.
REQ-023 Capture when level==DEPTH and no pop: word is dropped, overflow is set, level is unchanged.
REQ-024 Simultaneous capture and pop when full: both SHALL take effect; level stays DEPTH; overflow is not set.
REQ-025 Simultaneous capture and pop when level==1: the new word becomes the head next cycle; level stays 1.
REQ-026 out_ready while empty SHALL have no effect.
REQ-027 FIFO SHALL preserve capture order; read and write pointers wrap modulo DEPTH.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 While rst==0: FSM=HUNT, sl_prev=0, pointers=0, level=0, out_valid=0, out_data=0, frame_err=0, overflow=0, err_cnt=0.
REQ-030 Assertion of rst mid-frame SHALL discard the partial frame and all buffered words.
REQ-031 The first reclk after rst release SHALL evaluate as HUNT (sl==0 enters COLLECT).

Verification
REQ-032 Clean frame: sl=0..15, then 0 with din=16'hA5C3 at that edge -> next cycle out_valid=1, out_data=16'hA5C3, level=1, frame_err=0.
REQ-033 Skip: sl 0,1,2,4 -> frame_err pulses on the sl=4 edge, err_cnt=1, no capture; later sl=0..15,0 captures normally.
REQ-034 Overflow: DEPTH=4, out_ready=0, 5 clean frames -> level=4, overflow=1, out_data is the first word; then pop 4 -> words 1..4 in order.
REQ-035 Full with out_ready=1 on the capture edge -> level stays 4, overflow stays 0, the oldest word is removed and the newest word appended.
REQ-036 rst=0 asserted at sl=9 with level=2 -> all outputs 0 immediately; after release sl=10..15,0 produces no capture (HUNT until 0).

Source files
------------

// File: rtl/frame_capture.sv
// Frame capture: follows the memory unit's bit-select sequence and queues each
// completed 16-bit word into a DEPTH-entry FIFO with overflow and error tracking.
module frame_capture #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        reclk,
  input  logic        rst,
  input  logic [3:0]  sl,
  input  logic [15:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  level,
  output logic        frame_err,
  output logic        overflow,
  output logic [7:0]  err_cnt
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL_LVL = 5'(DEPTH);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    ARMED   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         sl_prev_q;
  logic               frame_err_q;
  logic [7:0]         err_cnt_q;
  logic               cap_c, err_c;

  logic [15:0]        mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [4:0]         level_q, level_d;
  logic               out_valid_q;
  logic [15:0]        out_data_q, out_data_d;
  logic               overflow_q;
  logic               pop_c, push_c, drop_c, full_c;

  // Sequence tracker: classify this edge's sl against the previous sample.
  always_comb begin
    state_d = state_q;
    cap_c   = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      HUNT: begin
        if (sl == 4'd0) state_d = COLLECT;
      end
      COLLECT: begin
        if (sl == sl_prev_q) begin
          state_d = COLLECT;
        end else if (sl == 4'(sl_prev_q + 4'd1)) begin
          state_d = (sl == 4'd15) ? ARMED : COLLECT;
        end else begin
          err_c = 1'b1;
        end
      end
      ARMED: begin
        if (sl == 4'd15) begin
          state_d = ARMED;
        end else if (sl == 4'd0) begin
          cap_c   = 1'b1;
          state_d = COLLECT;
        end else begin
          err_c = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    if (err_c) state_d = (sl == 4'd0) ? COLLECT : HUNT;
  end

  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      sl_prev_q   <= 4'd0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      sl_prev_q   <= sl;
      frame_err_q <= err_c;
      if (err_c && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // FIFO control; a pop frees a slot for a capture on the same edge.
  always_comb begin
    pop_c    = out_valid_q && out_ready;
    full_c   = (level_q == FULL_LVL);
    push_c   = cap_c && (!full_c || pop_c);
    drop_c   = cap_c && full_c && !pop_c;
    rd_ptr_d = pop_c  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    wr_ptr_d = push_c ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    level_d  = 5'(level_q + 5'(push_c) - 5'(pop_c));
    if (level_d == 5'd0) begin
      out_data_d = 16'h0000;
    end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = din;
    end else begin
      out_data_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge reclk) begin
    if (push_c) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      out_valid_q <= (level_d != 5'd0);
      out_data_q  <= out_data_d;
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: directed scenarios plus random sl/din/out_ready traffic,
// checked against a sequence-list reference model and a word scoreboard.
module tb_frame_capture;

  localparam int DEPTH = 4;

  logic        reclk;
  logic        rst;
  logic [3:0]  sl;
  logic [15:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  level;
  logic        frame_err;
  logic        overflow;
  logic [7:0]  err_cnt;

  frame_capture #(.DEPTH(DEPTH)) dut (
    .reclk     (reclk),
    .rst       (rst),
    .sl        (sl),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_cnt   (err_cnt)
  );

  initial reclk = 1'b0;
  always #5 reclk = ~reclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int        seq[$];
  bit        m_hunt = 1'b1;
  int        m_level = 0;
  bit        m_ferr = 1'b0;
  bit        m_ovf = 1'b0;
  int        m_errcnt = 0;
  bit [15:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit prefix_ok();
    if (seq.size() > 17) return 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      if (seq[k] != ((k == 16) ? 0 : k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    seq.delete();
    m_hunt = 1'b1;
    m_level = 0;
    m_ferr = 1'b0;
    m_ovf = 1'b0;
    m_errcnt = 0;
    exp_q.delete();
  endtask

  // A frame is the distinct-value sequence 0,1,..,15,0 with repeats collapsed.
  task automatic model_edge(input int s, input bit [15:0] d, input bit r);
    bit cap = 1'b0;
    bit err = 1'b0;
    bit pop, push;
    if (m_hunt) begin
      if (s == 0) begin
        m_hunt = 1'b0;
        seq.delete();
        seq.push_back(0);
      end
    end else if (s != seq[$]) begin
      seq.push_back(s);
      if (!prefix_ok()) begin
        err = 1'b1;
        seq.delete();
        if (s == 0) seq.push_back(0);
        else m_hunt = 1'b1;
      end else if (seq.size() == 17) begin
        cap = 1'b1;
        seq.delete();
        seq.push_back(0);
      end
    end
    pop  = (m_level > 0) && r;
    push = 1'b0;
    if (cap) begin
      if ((m_level < DEPTH) || pop) begin
        push = 1'b1;
        exp_q.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_level = m_level + int'(push) - int'(pop);
    m_ferr = err;
    if (err && (m_errcnt < 255)) m_errcnt++;
  endtask

  // Called just after a falling edge: check outputs of the last rising edge, drive, advance.
  task automatic step(input int s, input bit [15:0] d, input bit r);
    chk("level", int'(level), m_level);
    chk("out_valid", int'(out_valid), int'(m_level != 0));
    chk("frame_err", int'(frame_err), int'(m_ferr));
    chk("err_cnt", int'(err_cnt), m_errcnt);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (m_level == 0) chk("out_data_empty", int'(out_data), 0);
    else if (exp_q.size() > 0) chk("out_data_head", int'(out_data), int'(exp_q[0]));
    sl = 4'(s);
    din = d;
    out_ready = r;
    model_edge(s, d, r);
    @(negedge reclk);
  endtask

  task automatic frame(input bit [15:0] w, input bit r_last);
    for (int s = 1; s < 16; s++) step(s, 16'($urandom), 1'b0);
    step(0, w, r_last);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_errcnt", int'(err_cnt), 0);
    model_reset();
    @(negedge reclk);
    @(negedge reclk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: a pop on the coming edge must present the oldest expected word.
  initial begin
    forever begin
      @(negedge reclk);
      #2;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          chk("pop_word", int'(out_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int gs;
    bit rb;
    int r;
    rst = 1'b0;
    sl = 4'd0;
    din = 16'h0;
    out_ready = 1'b0;
    model_reset();
    @(negedge reclk);
    @(negedge reclk);
    do_reset();

    // Clean frame then a skip error then a clean frame
    step(0, 16'h1111, 1'b0);
    frame(16'hA5C3, 1'b0);
    step(1, 16'h0, 1'b0);
    step(2, 16'h0, 1'b0);
    step(4, 16'h0, 1'b0);
    step(4, 16'h0, 1'b0);
    step(0, 16'h0, 1'b0);
    frame(16'h5A3C, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1'b1);

    // Overflow with five frames, then drain
    do_reset();
    step(0, 16'h0, 1'b0);
    for (int i = 1; i <= 5; i++) frame(16'(16'h1000 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(0, 16'h0, 1'b1);

    // Full plus simultaneous pop on the capture edge
    do_reset();
    step(0, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) frame(16'(16'h2000 + i), 1'b0);
    frame(16'h2005, 1'b1);
    step(0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 16'h0, 1'b1);

    // Level-1 capture with pop
    step(0, 16'h0, 1'b0);
    frame(16'h3001, 1'b0);
    frame(16'h3002, 1'b1);
    step(0, 16'h0, 1'b1);
    step(0, 16'h0, 1'b0);

    // Reset mid-frame with two buffered words
    do_reset();
    step(0, 16'h0, 1'b0);
    frame(16'h4001, 1'b0);
    frame(16'h4002, 1'b0);
    for (int s = 1; s <= 9; s++) step(s, 16'h0, 1'b0);
    do_reset();
    for (int s = 10; s <= 15; s++) step(s, 16'h0, 1'b0);
    step(0, 16'h4444, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1'b1);

    // Random traffic
    gs = 0;
    rb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) gs = int'($urandom_range(0, 15));
      else if (r >= 15) gs = (gs + 1) % 16;
      if ((i % 200) < 100) rb = ($urandom_range(0, 9) < 2);
      else rb = ($urandom_range(0, 9) < 7);
      step(gs, 16'($urandom), rb);
    end

    // Drain everything remaining
    step(5, 16'h0, 1'b1);
    for (int i = 0; i < DEPTH + 3; i++) step(5, 16'h0, 1'b1);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
